// File: rtl/ex_mc_ctrl.sv
// Multi-cycle execute controller: sequences two-cycle MAC and iterative divide in EX,
// drives the divider handshake and the pipeline stall vector.
module ex_mc_ctrl #(
  parameter int unsigned DIV_TIMEOUT = 40,
  parameter int unsigned CNT_W       = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_id,
  input  logic        ex_mc_valid,
  input  logic [1:0]  ex_mc_op,
  input  logic [63:0] ex_prod,
  input  logic        flush,
  input  logic        div_ready,
  output logic [5:0]  stall,
  output logic [63:0] hilo_temp,
  output logic [1:0]  mac_cnt,
  output logic        div_start,
  output logic        div_signed,
  output logic        div_annul,
  output logic        div_timeout
);

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StMac2    = 2'd1,
    StDivRun  = 2'd2,
    StDivDone = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(DIV_TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [63:0]       hilo_q, hilo_d;
  logic [1:0]        mac_cnt_q, mac_cnt_d;
  logic              div_start_q, div_start_d;
  logic              div_signed_q, div_signed_d;
  logic              div_annul_q, div_annul_d;
  logic              div_timeout_q, div_timeout_d;
  logic              mc_req;
  logic              stallreq_ex;

  assign mc_req = ex_mc_valid && (ex_mc_op != 2'b00);

  always_comb begin
    stallreq_ex = 1'b0;
    unique case (state_q)
      StIdle:   stallreq_ex = mc_req;
      StDivRun: stallreq_ex = !div_ready;
      default:  stallreq_ex = 1'b0;
    endcase
  end

  // 001111 also holds ex_mem's input, so ex_mem writes a bubble while EX is held.
  always_comb begin
    stall = 6'b000000;
    if (!rst || flush) begin
      stall = 6'b000000;
    end else if (stallreq_ex) begin
      stall = 6'b001111;
    end else if (stallreq_id) begin
      stall = 6'b000111;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    hilo_d        = hilo_q;
    mac_cnt_d     = 2'd0;
    div_start_d   = div_start_q;
    div_signed_d  = div_signed_q;
    div_annul_d   = 1'b0;
    div_timeout_d = div_timeout_q;
    if (flush) begin
      state_d     = StIdle;
      div_start_d = 1'b0;
      div_annul_d = (state_q == StDivRun);
    end else begin
      unique case (state_q)
        StIdle: begin
          if (mc_req) begin
            if (ex_mc_op == 2'b01) begin
              hilo_d    = ex_prod;
              mac_cnt_d = 2'd1;
              state_d   = StMac2;
            end else begin
              state_d      = StDivRun;
              div_start_d  = 1'b1;
              div_signed_d = ~ex_mc_op[0];
              cnt_d        = '0;
            end
          end
        end
        StMac2: state_d = StIdle;
        StDivRun: begin
          cnt_d = cnt_q + CNT_W'(1);
          if (div_ready) begin
            state_d     = StDivDone;
            div_start_d = 1'b0;
          end else if (cnt_q == CntLast) begin
            state_d       = StIdle;
            div_start_d   = 1'b0;
            div_annul_d   = 1'b1;
            div_timeout_d = 1'b1;
          end
        end
        // Gives the still-present EX instruction one cycle to leave before re-evaluation.
        StDivDone: state_d = StIdle;
        default:   state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      hilo_q        <= '0;
      mac_cnt_q     <= 2'd0;
      div_start_q   <= 1'b0;
      div_signed_q  <= 1'b0;
      div_annul_q   <= 1'b0;
      div_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      hilo_q        <= hilo_d;
      mac_cnt_q     <= mac_cnt_d;
      div_start_q   <= div_start_d;
      div_signed_q  <= div_signed_d;
      div_annul_q   <= div_annul_d;
      div_timeout_q <= div_timeout_d;
    end
  end

  assign hilo_temp   = hilo_q;
  assign mac_cnt     = mac_cnt_q;
  assign div_start   = div_start_q;
  assign div_signed  = div_signed_q;
  assign div_annul   = div_annul_q;
  assign div_timeout = div_timeout_q;

endmodule

// File: tb/tb_ex_mc_ctrl.sv
// Directed bench for ex_mc_ctrl: per-cycle comparison against a transaction-level model
// plus hand-computed literal checks.
module tb_ex_mc_ctrl;

  localparam int unsigned DIV_TIMEOUT = 40;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stallreq_id = 1'b0;
  logic        ex_mc_valid = 1'b0;
  logic [1:0]  ex_mc_op = 2'b00;
  logic [63:0] ex_prod = '0;
  logic        flush = 1'b0;
  logic        div_ready = 1'b0;
  logic [5:0]  stall;
  logic [63:0] hilo_temp;
  logic [1:0]  mac_cnt;
  logic        div_start, div_signed, div_annul, div_timeout;

  int n_tests = 0;
  int n_fail  = 0;

  ex_mc_ctrl #(.DIV_TIMEOUT(DIV_TIMEOUT), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .stallreq_id(stallreq_id), .ex_mc_valid(ex_mc_valid),
    .ex_mc_op(ex_mc_op), .ex_prod(ex_prod), .flush(flush), .div_ready(div_ready),
    .stall(stall), .hilo_temp(hilo_temp), .mac_cnt(mac_cnt), .div_start(div_start),
    .div_signed(div_signed), .div_annul(div_annul), .div_timeout(div_timeout)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Transaction-level model: what op is in flight and how long a divide has run.
  bit          m_mac_second = 0;
  bit          m_div_busy   = 0;
  bit          m_div_done   = 0;
  int          m_div_cycles = 0;
  logic [63:0] m_hilo   = '0;
  bit          m_signed = 0;
  bit          m_annul  = 0;
  bit          m_to     = 0;

  initial forever begin
    @(posedge clk or negedge rst);
    if (!rst) begin
      m_mac_second = 0; m_div_busy = 0; m_div_done = 0; m_div_cycles = 0;
      m_hilo = '0; m_signed = 0; m_annul = 0; m_to = 0;
    end else begin
      m_annul = 0;
      if (flush) begin
        if (m_div_busy) m_annul = 1;
        m_mac_second = 0; m_div_busy = 0; m_div_done = 0;
      end else if (m_mac_second) begin
        m_mac_second = 0;
      end else if (m_div_done) begin
        m_div_done = 0;
      end else if (m_div_busy) begin
        m_div_cycles++;
        if (div_ready) begin
          m_div_busy = 0; m_div_done = 1;
        end else if (m_div_cycles >= DIV_TIMEOUT) begin
          m_div_busy = 0; m_annul = 1; m_to = 1;
        end
      end else if (ex_mc_valid && ex_mc_op == 2'b01) begin
        m_hilo = ex_prod; m_mac_second = 1;
      end else if (ex_mc_valid && ex_mc_op[1]) begin
        m_div_busy = 1; m_div_cycles = 0; m_signed = !ex_mc_op[0];
      end
    end
  end

  initial forever begin
    logic [5:0] e_stall;
    bit         idle, ex_req;
    @(negedge clk);
    idle   = !m_mac_second && !m_div_busy && !m_div_done;
    ex_req = (idle && ex_mc_valid && ex_mc_op != 2'b00) || (m_div_busy && !div_ready);
    if (!rst || flush)    e_stall = 6'b000000;
    else if (ex_req)      e_stall = 6'b001111;
    else if (stallreq_id) e_stall = 6'b000111;
    else                  e_stall = 6'b000000;
    chk("cycle", {stall, hilo_temp, mac_cnt, div_start, div_signed, div_annul, div_timeout},
        {e_stall, m_hilo, (m_mac_second ? 2'd1 : 2'd0), m_div_busy, m_signed, m_annul, m_to});
  end

  initial begin
    int n_st, n_start;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_stall", stall, 6'b000000);
    chk("rst_regs", {hilo_temp, mac_cnt, div_start, div_signed, div_annul, div_timeout}, '0);
    rst = 1'b1;

    // ID-only stall
    stallreq_id = 1'b1; #1;
    chk("id_stall", stall, 6'b000111);
    cyc(); stallreq_id = 1'b0;

    // MADD
    ex_mc_valid = 1'b1; ex_mc_op = 2'b01; ex_prod = 64'h0000_0001_FFFF_FFFE; #1;
    chk("mac1_stall", stall, 6'b001111);
    chk("mac1_cnt", mac_cnt, 2'd0);
    cyc(); #1;
    chk("mac2_stall", stall, 6'b000000);
    chk("mac2_cnt", mac_cnt, 2'd1);
    chk("mac2_hilo", hilo_temp, 64'h0000_0001_FFFF_FFFE);
    cyc(); ex_mc_valid = 1'b0; ex_mc_op = 2'b00; ex_prod = '0; #1;
    chk("mac3_cnt", mac_cnt, 2'd0);

    // DIV, ready 33 cycles after div_start rises, with simultaneous ID stall at entry
    ex_mc_valid = 1'b1; ex_mc_op = 2'b10; stallreq_id = 1'b1; #1;
    chk("div_entry_stall", stall, 6'b001111);
    n_st = (stall == 6'b001111) ? 1 : 0;
    n_start = 0;
    cyc(); stallreq_id = 1'b0;
    for (int k = 1; k <= 34; k++) begin
      div_ready = (k == 34); #1;
      if (stall == 6'b001111) n_st++;
      if (div_start && !div_ready) n_start++;
      if (k == 1) chk("div_signed", div_signed, 1'b1);
      cyc();
    end
    div_ready = 1'b0; #1;
    chk("div_done_stall", stall, 6'b000000);
    chk("div_done_start", div_start, 1'b0);
    chk("div_stall_cycles", n_st, 34);
    chk("div_start_cycles", n_start, 33);
    cyc(); ex_mc_valid = 1'b0; ex_mc_op = 2'b00;
    cyc(); #1;
    chk("div_no_restart", div_start, 1'b0);

    // Silent divider -> timeout, then a clean DIVU
    ex_mc_valid = 1'b1; ex_mc_op = 2'b10; cyc();
    repeat (DIV_TIMEOUT) cyc();
    ex_mc_valid = 1'b0; ex_mc_op = 2'b00; #1;
    chk("to_stall", stall, 6'b000000);
    chk("to_annul", div_annul, 1'b1);
    chk("to_sticky", div_timeout, 1'b1);
    chk("to_start", div_start, 1'b0);
    cyc(); #1;
    chk("to_annul_pulse", {div_annul, div_timeout}, 2'b01);
    ex_mc_valid = 1'b1; ex_mc_op = 2'b11; cyc(); #1;
    chk("divu_run", {stall, div_start, div_signed, div_timeout}, {6'b001111, 3'b101});
    cyc(); div_ready = 1'b1;
    cyc(); div_ready = 1'b0;
    cyc(); ex_mc_valid = 1'b0; ex_mc_op = 2'b00;

    // Flush colliding with div_ready
    ex_mc_valid = 1'b1; ex_mc_op = 2'b10; cyc();
    cyc();
    div_ready = 1'b1; flush = 1'b1; #1;
    chk("flush_stall", stall, 6'b000000);
    cyc(); div_ready = 1'b0; flush = 1'b0;
    ex_mc_op = 2'b01; ex_prod = 64'h0000_0000_0000_1234; #1;
    chk("flush_annul", {div_annul, div_start}, 2'b10);
    chk("flush_idle", stall, 6'b001111);
    cyc(); flush = 1'b1; #1;
    chk("flush_mac_stall", stall, 6'b000000);
    cyc(); flush = 1'b0; ex_mc_valid = 1'b0; ex_mc_op = 2'b00; #1;
    chk("flush_mac_cnt", mac_cnt, 2'd0);
    chk("flush_hilo_kept", hilo_temp, 64'h0000_0000_0000_1234);
    cyc();

    // Async reset in the middle of a divide
    ex_mc_valid = 1'b1; ex_mc_op = 2'b10; cyc();
    repeat (10) cyc();
    rst = 1'b0; #1;
    chk("rst_mid_stall", stall, 6'b000000);
    chk("rst_mid_regs", {hilo_temp, mac_cnt, div_start, div_signed, div_annul, div_timeout},
        '0);
    cyc(); rst = 1'b1; ex_mc_valid = 1'b0; ex_mc_op = 2'b00; #1;
    chk("post_rst_stall", stall, 6'b000000);
    repeat (3) cyc();
    ex_mc_valid = 1'b1; ex_mc_op = 2'b01; ex_prod = 64'h5; #1;
    chk("post_rst_mac", stall, 6'b001111);
    cyc(); cyc(); ex_mc_valid = 1'b0; ex_mc_op = 2'b00;
    repeat (2) cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
